// File: rtl/mem_dual_lanes.sv
`default_nettype none
// ============================================================================
// Module   : mem_dual_lanes
// Brief    : Dual-port lane-writable RAM with clear sequencer, selectable
//            read-during-write mode and optional output register.
// Revision : 1.0
// ============================================================================
module mem_dual_lanes #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 64,
  parameter int LANES    = 4,
  parameter int OUT_REG  = 0,
  parameter int RDW_MODE = 0,
  parameter int INIT     = 1
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     clear,
  output logic                     busy,
  input  logic [WIDTH-1:0]         data_0,
  input  logic [$clog2(DEPTH)-1:0] address_0,
  input  logic                     wren_0,
  input  logic [LANES-1:0]         be_0,
  input  logic                     rden_0,
  output logic [WIDTH-1:0]         q_0,
  output logic                     valid_0,
  input  logic [WIDTH-1:0]         data_1,
  input  logic [$clog2(DEPTH)-1:0] address_1,
  input  logic                     wren_1,
  input  logic [LANES-1:0]         be_1,
  input  logic                     rden_1,
  output logic [WIDTH-1:0]         q_1,
  output logic                     valid_1,
  output logic                     collision
);

  localparam int              c_aw       = $clog2(DEPTH);
  localparam int              c_lw       = WIDTH / LANES;
  localparam logic [c_aw:0]   c_depth    = (c_aw + 1)'(DEPTH);
  localparam logic [c_aw-1:0] c_last     = c_aw'(DEPTH - 1);
  localparam logic [0:0]      c_st_idle  = 1'b0;
  localparam logic [0:0]      c_st_clear = 1'b1;

  logic [WIDTH-1:0] r_mem [DEPTH];

  logic [0:0]      r_state;
  logic [0:0]      w_state_nxt;
  logic [c_aw-1:0] r_cnt;
  logic            r_boot;

  logic             w_ok_0, w_ok_1, w_wr_ok_0, w_wr_ok_1;
  logic [WIDTH-1:0] w_old_0, w_old_1, w_rd_0, w_rd_1;
  logic [WIDTH-1:0] r_q1_0, r_q1_1;
  logic             r_v1_0, r_v1_1;
  logic             r_collision;

  // r_boot launches the power-up clear on the first edge after reset release
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= c_st_idle;
      r_cnt   <= '0;
      r_boot  <= (INIT != 0);
    end else begin
      r_state <= w_state_nxt;
      r_boot  <= 1'b0;
      if (r_state == c_st_clear && r_cnt != c_last)
        r_cnt <= r_cnt + c_aw'(1);
      else
        r_cnt <= '0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:  if (r_boot || clear) w_state_nxt = c_st_clear;
      c_st_clear: if (r_cnt == c_last) w_state_nxt = c_st_idle;
      default:    w_state_nxt = c_st_idle;
    endcase
  end

  always_comb begin
    busy = (r_state == c_st_clear);
  end

  assign w_ok_0    = ({1'b0, address_0} < c_depth);
  assign w_ok_1    = ({1'b0, address_1} < c_depth);
  assign w_wr_ok_0 = wren_0 && w_ok_0;
  assign w_wr_ok_1 = wren_1 && w_ok_1;

  // Port 0 lanes are assigned last so they win on a shared address
  always_ff @(posedge clock) begin
    if (busy) begin
      r_mem[r_cnt] <= '0;
    end else begin
      for (int k = 0; k < LANES; k++)
        if (w_wr_ok_1 && be_1[k])
          r_mem[address_1][k*c_lw +: c_lw] <= data_1[k*c_lw +: c_lw];
      for (int k = 0; k < LANES; k++)
        if (w_wr_ok_0 && be_0[k])
          r_mem[address_0][k*c_lw +: c_lw] <= data_0[k*c_lw +: c_lw];
    end
  end

  assign w_old_0 = w_ok_0 ? r_mem[address_0] : '0;
  assign w_old_1 = w_ok_1 ? r_mem[address_1] : '0;

  // Write-first merges only this port's own write; the other port always sees old data
  always_comb begin
    w_rd_0 = w_old_0;
    w_rd_1 = w_old_1;
    if (RDW_MODE == 0) begin
      for (int k = 0; k < LANES; k++) begin
        if (w_wr_ok_0 && be_0[k]) w_rd_0[k*c_lw +: c_lw] = data_0[k*c_lw +: c_lw];
        if (w_wr_ok_1 && be_1[k]) w_rd_1[k*c_lw +: c_lw] = data_1[k*c_lw +: c_lw];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_q1_0      <= '0;
      r_q1_1      <= '0;
      r_v1_0      <= 1'b0;
      r_v1_1      <= 1'b0;
      r_collision <= 1'b0;
    end else begin
      r_v1_0 <= !busy && rden_0;
      r_v1_1 <= !busy && rden_1;
      if (!busy && rden_0) r_q1_0 <= w_rd_0;
      if (!busy && rden_1) r_q1_1 <= w_rd_1;
      r_collision <= !busy && w_wr_ok_0 && w_wr_ok_1 &&
                     (address_0 == address_1) && ((be_0 & be_1) != '0);
    end
  end

  assign collision = r_collision;

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [WIDTH-1:0] r_q2_0, r_q2_1;
      logic             r_v2_0, r_v2_1;

      // Not gated by busy so reads already in flight still complete
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          r_q2_0 <= '0;
          r_q2_1 <= '0;
          r_v2_0 <= 1'b0;
          r_v2_1 <= 1'b0;
        end else begin
          r_v2_0 <= r_v1_0;
          r_v2_1 <= r_v1_1;
          if (r_v1_0) r_q2_0 <= r_q1_0;
          if (r_v1_1) r_q2_1 <= r_q1_1;
        end
      end

      assign q_0     = r_q2_0;
      assign q_1     = r_q2_1;
      assign valid_0 = r_v2_0;
      assign valid_1 = r_v2_1;
    end else begin : g_no_out_reg
      assign q_0     = r_q1_0;
      assign q_1     = r_q1_1;
      assign valid_0 = r_v1_0;
      assign valid_1 = r_v1_1;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_mem_dual_lanes.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_dual_lanes
// Brief    : Directed vector bench for mem_dual_lanes (three configurations).
// Revision : 1.0
// ============================================================================
module tb_mem_dual_lanes;

  typedef struct packed {
    logic        wr0; logic [3:0] be0; logic [5:0] a0; logic [31:0] d0; logic rd0;
    logic        wr1; logic [3:0] be1; logic [5:0] a1; logic [31:0] d1; logic rd1;
    logic [31:0] q0;  logic v0; logic [31:0] q1; logic v1; logic col;
    logic [31:0] q0r; logic [31:0] q1r;
  } vec_t;

  logic        clock, reset_n, clear;
  logic [31:0] data_0, data_1;
  logic [5:0]  address_0, address_1;
  logic        wren_0, wren_1, rden_0, rden_1;
  logic [3:0]  be_0, be_1;

  logic [31:0] q0_d, q1_d, q0_r, q1_r, q0_o, q1_o;
  logic        v0_d, v1_d, v0_r, v1_r, v0_o, v1_o;
  logic        busy_d, busy_r, busy_o, col_d, col_r, col_o;

  int n_vec = 0;
  int n_bad = 0;
  vec_t vecs [19];

  mem_dual_lanes #(.OUT_REG(0), .RDW_MODE(0)) dut (
    .clock(clock), .reset_n(reset_n), .clear(clear), .busy(busy_d),
    .data_0(data_0), .address_0(address_0), .wren_0(wren_0), .be_0(be_0), .rden_0(rden_0),
    .q_0(q0_d), .valid_0(v0_d),
    .data_1(data_1), .address_1(address_1), .wren_1(wren_1), .be_1(be_1), .rden_1(rden_1),
    .q_1(q1_d), .valid_1(v1_d), .collision(col_d));

  mem_dual_lanes #(.OUT_REG(0), .RDW_MODE(1)) dut_rf (
    .clock(clock), .reset_n(reset_n), .clear(clear), .busy(busy_r),
    .data_0(data_0), .address_0(address_0), .wren_0(wren_0), .be_0(be_0), .rden_0(rden_0),
    .q_0(q0_r), .valid_0(v0_r),
    .data_1(data_1), .address_1(address_1), .wren_1(wren_1), .be_1(be_1), .rden_1(rden_1),
    .q_1(q1_r), .valid_1(v1_r), .collision(col_r));

  mem_dual_lanes #(.OUT_REG(1), .RDW_MODE(0)) dut_or (
    .clock(clock), .reset_n(reset_n), .clear(clear), .busy(busy_o),
    .data_0(data_0), .address_0(address_0), .wren_0(wren_0), .be_0(be_0), .rden_0(rden_0),
    .q_0(q0_o), .valid_0(v0_o),
    .data_1(data_1), .address_1(address_1), .wren_1(wren_1), .be_1(be_1), .rden_1(rden_1),
    .q_1(q1_o), .valid_1(v1_o), .collision(col_o));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    wren_0 = 0; be_0 = 0; address_0 = 0; data_0 = 0; rden_0 = 0;
    wren_1 = 0; be_1 = 0; address_1 = 0; data_1 = 0; rden_1 = 0;
  endtask

  task automatic drive(input vec_t t);
    wren_0 = t.wr0; be_0 = t.be0; address_0 = t.a0; data_0 = t.d0; rden_0 = t.rd0;
    wren_1 = t.wr1; be_1 = t.be1; address_1 = t.a1; data_1 = t.d1; rden_1 = t.rd1;
  endtask

  // Counts sample points with busy high; bounded so a stuck sequencer still ends
  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (busy_d) n++;
      else if (n > 0) break;
    end
  endtask

  initial begin
    int n;
    //          wr0  be0   a0     d0            rd0   wr1  be1   a1     d1            rd1   q0            v0    q1            v1    col   q0r           q1r
    vecs[0]  = '{1'b0,4'h0,6'd0, 32'h00000000,1'b1, 1'b0,4'h0,6'd0, 32'h00000000,1'b0, 32'h00000000,1'b1, 32'h00000000,1'b0, 1'b0, 32'h00000000,32'h00000000};
    vecs[1]  = '{1'b0,4'h0,6'd31,32'h00000000,1'b1, 1'b0,4'h0,6'd0, 32'h00000000,1'b0, 32'h00000000,1'b1, 32'h00000000,1'b0, 1'b0, 32'h00000000,32'h00000000};
    vecs[2]  = '{1'b0,4'h0,6'd63,32'h00000000,1'b1, 1'b0,4'h0,6'd63,32'h00000000,1'b1, 32'h00000000,1'b1, 32'h00000000,1'b1, 1'b0, 32'h00000000,32'h00000000};
    vecs[3]  = '{1'b1,4'hF,6'd5, 32'hAABBCCDD,1'b0, 1'b0,4'h0,6'd0, 32'h00000000,1'b0, 32'h00000000,1'b0, 32'h00000000,1'b0, 1'b0, 32'h00000000,32'h00000000};
    vecs[4]  = '{1'b1,4'h5,6'd5, 32'h11223344,1'b0, 1'b0,4'h0,6'd0, 32'h00000000,1'b0, 32'h00000000,1'b0, 32'h00000000,1'b0, 1'b0, 32'h00000000,32'h00000000};
    vecs[5]  = '{1'b0,4'h0,6'd0, 32'h00000000,1'b0, 1'b0,4'h0,6'd5, 32'h00000000,1'b1, 32'h00000000,1'b0, 32'hAA22CC44,1'b1, 1'b0, 32'h00000000,32'hAA22CC44};
    vecs[6]  = '{1'b1,4'h3,6'd9, 32'hFFFFFFFF,1'b0, 1'b1,4'h6,6'd9, 32'h00000000,1'b0, 32'h00000000,1'b0, 32'hAA22CC44,1'b0, 1'b1, 32'h00000000,32'hAA22CC44};
    vecs[7]  = '{1'b0,4'h0,6'd9, 32'h00000000,1'b1, 1'b0,4'h0,6'd0, 32'h00000000,1'b0, 32'h0000FFFF,1'b1, 32'hAA22CC44,1'b0, 1'b0, 32'h0000FFFF,32'hAA22CC44};
    vecs[8]  = '{1'b1,4'hF,6'd3, 32'h12345678,1'b0, 1'b0,4'h0,6'd0, 32'h00000000,1'b0, 32'h0000FFFF,1'b0, 32'hAA22CC44,1'b0, 1'b0, 32'h0000FFFF,32'hAA22CC44};
    vecs[9]  = '{1'b1,4'hF,6'd3, 32'hCAFEBABE,1'b1, 1'b0,4'h0,6'd3, 32'h00000000,1'b1, 32'hCAFEBABE,1'b1, 32'h12345678,1'b1, 1'b0, 32'h12345678,32'h12345678};
    vecs[10] = '{1'b0,4'h0,6'd3, 32'h00000000,1'b1, 1'b0,4'h0,6'd5, 32'h00000000,1'b1, 32'hCAFEBABE,1'b1, 32'hAA22CC44,1'b1, 1'b0, 32'hCAFEBABE,32'hAA22CC44};
    vecs[11] = '{1'b1,4'h0,6'd7, 32'hDEADBEEF,1'b0, 1'b0,4'h0,6'd7, 32'h00000000,1'b1, 32'hCAFEBABE,1'b0, 32'h00000000,1'b1, 1'b0, 32'hCAFEBABE,32'h00000000};
    vecs[12] = '{1'b0,4'h0,6'd7, 32'h00000000,1'b1, 1'b0,4'h0,6'd0, 32'h00000000,1'b0, 32'h00000000,1'b1, 32'h00000000,1'b0, 1'b0, 32'h00000000,32'h00000000};
    vecs[13] = '{1'b1,4'h8,6'd9, 32'h5A000000,1'b0, 1'b1,4'h1,6'd9, 32'h000000A5,1'b0, 32'h00000000,1'b0, 32'h00000000,1'b0, 1'b0, 32'h00000000,32'h00000000};
    vecs[14] = '{1'b0,4'h0,6'd9, 32'h00000000,1'b1, 1'b0,4'h0,6'd0, 32'h00000000,1'b0, 32'h5A00FFA5,1'b1, 32'h00000000,1'b0, 1'b0, 32'h5A00FFA5,32'h00000000};
    vecs[15] = '{1'b0,4'h0,6'd0, 32'h00000000,1'b0, 1'b1,4'hC,6'd10,32'h87654321,1'b1, 32'h5A00FFA5,1'b0, 32'h87650000,1'b1, 1'b0, 32'h5A00FFA5,32'h00000000};
    vecs[16] = '{1'b0,4'h0,6'd0, 32'h00000000,1'b0, 1'b0,4'h0,6'd10,32'h00000000,1'b1, 32'h5A00FFA5,1'b0, 32'h87650000,1'b1, 1'b0, 32'h5A00FFA5,32'h87650000};
    vecs[17] = '{1'b0,4'h0,6'd3, 32'h00000000,1'b1, 1'b1,4'hF,6'd3, 32'h0BADF00D,1'b0, 32'hCAFEBABE,1'b1, 32'h87650000,1'b0, 1'b0, 32'hCAFEBABE,32'h87650000};
    vecs[18] = '{1'b0,4'h0,6'd3, 32'h00000000,1'b1, 1'b0,4'h0,6'd3, 32'h00000000,1'b1, 32'h0BADF00D,1'b1, 32'h0BADF00D,1'b1, 1'b0, 32'h0BADF00D,32'h0BADF00D};

    reset_n = 1'b0; clear = 1'b0; idle();
    repeat (3) @(posedge clock);
    #1;
    chk("reset q_0", q0_d, 32'h0);
    chk("reset valid_0", {31'b0, v0_d}, 32'h0);
    chk("reset collision", {31'b0, col_d}, 32'h0);
    chk("reset busy", {31'b0, busy_d}, 32'h0);

    // Power-up clear
    reset_n = 1'b1;
    count_busy(n);
    chk("init busy cycles", n, 64);

    for (int i = 0; i < 19; i++) begin
      drive(vecs[i]);
      step();
      chk($sformatf("v%0d q_0", i), q0_d, vecs[i].q0);
      chk($sformatf("v%0d valid_0", i), {31'b0, v0_d}, {31'b0, vecs[i].v0});
      chk($sformatf("v%0d q_1", i), q1_d, vecs[i].q1);
      chk($sformatf("v%0d valid_1", i), {31'b0, v1_d}, {31'b0, vecs[i].v1});
      chk($sformatf("v%0d collision", i), {31'b0, col_d}, {31'b0, vecs[i].col});
      chk($sformatf("v%0d rf q_0", i), q0_r, vecs[i].q0r);
      chk($sformatf("v%0d rf q_1", i), q1_r, vecs[i].q1r);
    end
    idle();

    // Pipelined reads through the output register
    wren_1 = 1; be_1 = 4'hF; address_1 = 6'd1; data_1 = 32'h11111111; step();
    address_1 = 6'd2; data_1 = 32'h22222222; step();
    idle();
    rden_0 = 1; address_0 = 6'd1; step();
    chk("or E1 valid_0", {31'b0, v0_o}, 32'h0);
    chk("lat1 E1 q_0", q0_d, 32'h11111111);
    address_0 = 6'd2; step();
    chk("or E2 valid_0", {31'b0, v0_o}, 32'h1);
    chk("or E2 q_0", q0_o, 32'h11111111);
    address_0 = 6'd3; step();
    rden_0 = 0;
    chk("or E3 valid_0", {31'b0, v0_o}, 32'h1);
    chk("or E3 q_0", q0_o, 32'h22222222);
    step();
    chk("or E4 valid_0", {31'b0, v0_o}, 32'h1);
    chk("or E4 q_0", q0_o, 32'h0BADF00D);
    step();
    chk("or E5 valid_0", {31'b0, v0_o}, 32'h0);
    chk("or E5 q_0 hold", q0_o, 32'h0BADF00D);

    // Clear pulse, ignored re-pulse, and a write/read attempted while busy
    clear = 1; step(); clear = 0;
    n = busy_d ? 1 : 0;
    for (int i = 0; i < 200 && busy_d; i++) begin
      if (n == 10) clear = 1;
      if (n == 12) begin
        wren_0 = 1; be_0 = 4'hF; address_0 = 6'd5; data_0 = 32'hFFFFFFFF; rden_0 = 1;
      end
      step();
      clear = 0;
      if (n == 12) begin
        chk("busy valid_0", {31'b0, v0_d}, 32'h0);
        chk("busy q_0 hold", q0_d, 32'h0BADF00D);
        idle();
      end
      if (busy_d) n++;
    end
    chk("clear busy cycles", n, 64);
    rden_0 = 1; address_0 = 6'd5; step(); rden_0 = 0;
    chk("post-clear a5", q0_d, 32'h0);
    chk("post-clear valid_0", {31'b0, v0_d}, 32'h1);

    // Reset in the middle of a clear, then INIT restart
    clear = 1; step(); clear = 0;
    repeat (29) step();
    chk("mid-clear busy", {31'b0, busy_d}, 32'h1);
    reset_n = 1'b0;
    #1;
    chk("async reset busy", {31'b0, busy_d}, 32'h0);
    chk("async reset q_0", q0_d, 32'h0);
    step();
    reset_n = 1'b1;
    count_busy(n);
    chk("restart busy cycles", n, 64);
    chk("restart busy_o", {31'b0, busy_o}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
